// File: rtl/gate_pkg.sv
// Gate counter shared types.
// FSM state encoding and the default occupancy limit.
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    E1,
    E2,
    E3,
    X1,
    X2,
    X3,
    ABORT
  } gate_state_t;

  localparam int CNT_MAX_DEF = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous sensor bit.
// Clears with the block's synchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_counter.sv
// Two-beam gate occupancy counter.
// Tracks entry/exit beam sequences and keeps a saturating count.
module gate_counter
  import gate_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  output logic [1:0] cnt,
  output logic       enter_pulse,
  output logic       exit_pulse,
  output logic       full,
  output logic       empty
);

  localparam logic [1:0] MAX = CNT_MAX[1:0];

  logic        sa;
  logic        sb;
  logic [1:0]  p;
  logic        inc;
  logic        dec;
  gate_state_t state;
  gate_state_t nxt;

  sync2 u_sync_a (
    .clk  (clk),
    .reset(reset),
    .d    (a),
    .q    (sa)
  );

  sync2 u_sync_b (
    .clk  (clk),
    .reset(reset),
    .d    (b),
    .q    (sb)
  );

  assign p = {sa, sb};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Each step holds on its own pattern and backs up on the previous one.
  always_comb begin
    nxt = state;
    inc = 1'b0;
    dec = 1'b0;
    unique case (state)
      IDLE: begin
        if (p == 2'b10)      nxt = E1;
        else if (p == 2'b01) nxt = X1;
        else if (p == 2'b11) nxt = ABORT;
      end
      E1: begin
        if (p == 2'b11)      nxt = E2;
        else if (p == 2'b00) nxt = IDLE;
        else if (p == 2'b01) nxt = ABORT;
      end
      E2: begin
        if (p == 2'b01)      nxt = E3;
        else if (p == 2'b10) nxt = E1;
        else if (p == 2'b00) nxt = ABORT;
      end
      E3: begin
        if (p == 2'b00) begin
          nxt = IDLE;
          inc = 1'b1;
        end
        else if (p == 2'b11) nxt = E2;
        else if (p == 2'b10) nxt = ABORT;
      end
      X1: begin
        if (p == 2'b11)      nxt = X2;
        else if (p == 2'b00) nxt = IDLE;
        else if (p == 2'b10) nxt = ABORT;
      end
      X2: begin
        if (p == 2'b10)      nxt = X3;
        else if (p == 2'b01) nxt = X1;
        else if (p == 2'b00) nxt = ABORT;
      end
      X3: begin
        if (p == 2'b00) begin
          nxt = IDLE;
          dec = 1'b1;
        end
        else if (p == 2'b11) nxt = X2;
        else if (p == 2'b01) nxt = ABORT;
      end
      ABORT: begin
        if (p == 2'b00) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= 2'd0;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      enter_pulse <= inc;
      exit_pulse  <= dec;
      if (inc && cnt != MAX)
        cnt <= cnt + 2'd1;
      else if (dec && cnt != 2'd0)
        cnt <= cnt - 2'd1;
    end
  end

  assign full  = (cnt == MAX);
  assign empty = (cnt == 2'd0);

endmodule

// File: tb/tb_gate_counter.sv
// Self-checking bench for gate_counter.
// Expected pulses are queued at stimulus time and popped on DUT pulses.
module tb_gate_counter;
  import gate_pkg::*;

  logic       clk;
  logic       reset;
  logic       a;
  logic       b;
  logic [1:0] cnt;
  logic       enter_pulse;
  logic       exit_pulse;
  logic       full;
  logic       empty;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks;
  int  failures;
  int  exp_cnt;

  gate_counter #(.CNT_MAX(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .cnt        (cnt),
    .enter_pulse(enter_pulse),
    .exit_pulse (exit_pulse),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: every strobe must match the next queued event.
  always @(negedge clk) begin
    if (reset && (enter_pulse || exit_pulse)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'({enter_pulse, exit_pulse}), 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_kind", int'({enter_pulse, exit_pulse}), int'(e.kind));
        check("pulse_cnt", int'(cnt), int'(e.cnt));
      end
    end
  end

  task automatic drive(input logic [1:0] pat, input int n);
    {a, b} = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    drive(2'b00, 6);
    check(tag, exp_q.size(), 0);
    check({tag, "_cnt"}, int'(cnt), exp_cnt);
    check({tag, "_empty"}, int'(empty), int'(exp_cnt == 0));
    check({tag, "_full"}, int'(full), int'(exp_cnt == 3));
  endtask

  task automatic do_entry(input string tag);
    ev_t e;
    if (exp_cnt < 3) exp_cnt++;
    e.kind = 2'b10;
    e.cnt  = 2'(exp_cnt);
    exp_q.push_back(e);
    drive(2'b10, 4);
    drive(2'b11, 4);
    drive(2'b01, 4);
    settle(tag);
  endtask

  task automatic do_exit(input string tag);
    ev_t e;
    if (exp_cnt > 0) exp_cnt--;
    e.kind = 2'b01;
    e.cnt  = 2'(exp_cnt);
    exp_q.push_back(e);
    drive(2'b01, 4);
    drive(2'b11, 4);
    drive(2'b10, 4);
    settle(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    reset    = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cnt", int'(cnt), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_enter", int'(enter_pulse), 0);
    check("rst_exit", int'(exit_pulse), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    reset = 1'b1;
    drive(2'b00, 2);

    do_exit("exit_at_zero");
    do_entry("entry1");

    drive(2'b10, 4);
    drive(2'b11, 4);
    drive(2'b10, 4);
    settle("reversal");

    drive(2'b10, 4);
    drive(2'b01, 4);
    check("abort_state", int'(dut.state), int'(ABORT));
    settle("abort");

    do_entry("entry2");
    do_entry("entry3");
    do_entry("entry_sat");
    do_exit("exit_from_full");

    drive(2'b10, 4);
    drive(2'b11, 4);
    check("in_e2", int'(dut.state), int'(E2));
    a     = 1'b0;
    b     = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    check("midrst_cnt", int'(cnt), 0);
    check("midrst_state", int'(dut.state), int'(IDLE));
    check("midrst_enter", int'(enter_pulse), 0);
    check("midrst_empty", int'(empty), 1);
    reset = 1'b1;
    settle("post_reset");
    do_entry("entry_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_counter.md
GATE_COUNTER -- requirements
Module: gate_counter

Interface
REQ-001 Parameter: CNT_MAX, default 3, saturation limit of the occupancy count; it must fit in 2 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; reset=0 sampled on a clk rising edge resets the block.
REQ-004 a  input  1  outer gate sensor, asynchronous to clk, 1=beam blocked.
REQ-005 b  input  1  inner gate sensor, asynchronous to clk, 1=beam blocked.
REQ-006 cnt  output  2  current occupancy; cnt[1] drives the display stage sw1 input and cnt[0] drives sw0.
REQ-007 enter_pulse  output  1  one-cycle strobe for a completed entry.
REQ-008 exit_pulse  output  1  one-cycle strobe for a completed exit.
REQ-009 full  output  1  high when cnt==CNT_MAX.
REQ-010 empty  output  1  high when cnt==0.

Function
REQ-011 a and b each pass through a 2-flop synchronizer; the FSM sees sa/sb two cycles after the raw input changes.
REQ-012 The FSM states are IDLE, E1, E2, E3, X1, X2, X3 and ABORT; the pattern p={sa,sb} is evaluated on every clock edge.
REQ-013 Entry sequence: IDLE -p=10-> E1 -p=11-> E2 -p=01-> E3 -p=00-> IDLE with entry complete.
REQ-014 Exit sequence: IDLE -p=01-> X1 -p=11-> X2 -p=10-> X3 -p=00-> IDLE with exit complete.
REQ-015 In any E or X state, a pattern equal to that state's own pattern holds the state.
REQ-016 In any E or X state, a pattern equal to the previous step's pattern returns to the previous state (reversing vehicle); this includes E1/X1 with p=00 returning to IDLE without counting.
REQ-017 In any E or X state, any other pattern goes to ABORT; ABORT holds until p=00 and then goes to IDLE without counting.
REQ-018 IDLE with p=11 goes to ABORT.
REQ-019 The E3->IDLE edge increments cnt on that same edge and asserts enter_pulse for exactly one cycle, unless cnt==CNT_MAX.
REQ-020 On an entry at cnt==CNT_MAX, cnt holds (saturates) and enter_pulse still asserts.
REQ-021 The X3->IDLE edge decrements cnt and asserts exit_pulse for one cycle; at cnt==0, cnt holds (no wrap to 3) and exit_pulse still asserts.
REQ-022 Latency: a raw 00 arriving at cycle t while the FSM is in E3 or X3 produces a cnt and pulse change visible after edge t+3.
REQ-023 full and empty are decoded combinationally from the registered cnt.
REQ-024 enter_pulse and exit_pulse are never high in the same cycle.

Reset
REQ-025 While reset=0 at a clock edge: synchronizers clear to 0, FSM goes to IDLE, cnt=0, enter_pulse=0, exit_pulse=0; therefore empty=1 and full=0.
REQ-026 Reset asserted mid-sequence discards the partial sequence and produces no pulse.
REQ-027 After reset deasserts, the first FSM evaluation uses the synchronizer contents, which are cleared to 0.

Structure
REQ-028 Shared package gate_pkg holds the FSM state enum (gate_state_t) and the CNT_MAX default constant.
REQ-029 A sub-module sync2 (1-bit, 2-flop, same clk and reset) is instantiated once per sensor.
REQ-030 The top module contains the FSM, the count register and the output decode only.

Verification
REQ-031 Reset with reset=0 for 2 cycles -> cnt=00, empty=1, full=0, no pulses.
REQ-032 a/b driven 10,11,01,00, each held 4 cycles -> cnt 0->1, one enter_pulse, no exit_pulse.
REQ-033 Four entries from cnt=0 -> cnt=3 and full=1 after the third entry; the fourth entry pulses enter_pulse but cnt stays 3.
REQ-034 Exit sequence 01,11,10,00 at cnt=0 -> exit_pulse once, cnt stays 0, empty=1.
REQ-035 Partial entry 10,11,10,00 (reversal) -> FSM returns to IDLE, cnt unchanged, no pulses; sequence 10,01,00 -> ABORT then IDLE, cnt unchanged.
REQ-036 reset=0 while the FSM is in E2 with cnt=2 -> cnt=0 and FSM=IDLE next cycle, no enter_pulse.
